bg_mean_calc: RTL and testbench
===============================

// Module: bg_mean_calc
// PURPOSE
//  Computes the expected background colour (red_exp/green_exp/blue_exp) fed to every pe block.
//  Takes the packed per-PE channel values produced in the summing phase, averages only the
//  PEs enabled in pe_mask, rounds to nearest, and presents 8-bit means for the bg-removal phase.
//  Sequential: one PE accumulated per cycle, then a bit-serial restoring divide.
// PARAMETERS
//  NUM_PE  4  number of processing elements / packed 8-bit lanes per channel bus
//  (local) CW    = $clog2(NUM_PE+1)  width of enabled-PE count
//  (local) ACC_W = 8 + CW            accumulator / dividend width
// PORTS
//  Clk         in   1         rising-edge clock
//  Reset       in   1         synchronous, active-high reset
//  Start       in   1         request new mean; sampled only in Qi
//  Ack         in   1         acknowledges result; sampled only in Qd
//  pe_mask     in   NUM_PE    bit i=1 -> lane i contributes
//  red_sum_in  in   8*NUM_PE  lane i = bits [8i+7:8i]
//  green_sum_in in  8*NUM_PE  as above
//  blue_sum_in in   8*NUM_PE  as above
//  red_exp     out  8         rounded mean of enabled red lanes
//  green_exp   out  8         rounded mean of enabled green lanes
//  blue_exp    out  8         rounded mean of enabled blue lanes
//  pe_count    out  CW        number of enabled lanes used for last result
//  zero_cnt    out  1         1 = last result had pe_mask==0 (means forced 0)
//  Qi,Qacc,Qdiv,Qd out 1 each one-hot state flags
// BEHAVIOUR
//  - Reset (sync, any state): state=Qi; red/green/blue_exp=0, pe_count=0, zero_cnt=0,
//    accumulators/index/quotients cleared. Reset in mid-operation aborts; no partial result.
//  - Qi: Start=1 at edge -> latch pe_mask and all three sum buses, clear accs/count, idx=0,
//    go Qacc. Start=0 -> stay. Start in any other state ignored.
//  - Qacc: each edge: if mask[idx] add lane idx to each channel acc (ACC_W bits, no overflow
//    possible) and count+=1; idx+=1. Edge with idx==NUM_PE-1 -> Qdiv. Exactly NUM_PE cycles.
//  - Qdiv entry: dividend_c = acc_c + (count>>1) (round-half-up); divisor = count.
//    Restoring division MSB-first, one quotient bit per edge, three channels in parallel
//    sharing the divisor; exactly ACC_W cycles. Quotient <= 255 by construction; take [7:0].
//    count==0: skip arithmetic result, quotients forced 0, zero_cnt=1 (still ACC_W cycles).
//  - Last Qdiv edge: register red/green/blue_exp, pe_count, zero_cnt; go Qd.
//  - Qd: outputs stable; Ack=1 at edge -> Qi. Ack=0 -> stay. Ack held high => Qd lasts 1 cycle.
//  - Outputs hold last result in Qi/Qacc/Qdiv until overwritten at next Qdiv->Qd or Reset.
//  - Latency: Start edge to first cycle with Qd=1 = NUM_PE + ACC_W + 1 edges (16 for NUM_PE=4).
//  - Exactly one of Qi/Qacc/Qdiv/Qd high at all times after reset.
//  - Input buses may change after the Start edge without affecting the result.
// TESTING (NUM_PE=4, ACC_W=11)
//  1 Reset 6 cycles -> Qi=1, others 0; all exp=0, pe_count=0, zero_cnt=0.
//  2 mask=4'b1111, red lanes 61,61,61,61, green 10,20,30,41, blue 255x4, Start 1 cycle
//    -> Qd after 16 edges; red_exp=61, green_exp=25, blue_exp=255, pe_count=4, zero_cnt=0.
//  3 mask=4'b0011, red lanes 10,11,x,x (x=200) -> red_exp=11 (round-half-up), pe_count=2.
//  4 mask=4'b0000, any lanes -> all exp=0, zero_cnt=1, pe_count=0, Qd still at 16 edges.
//  5 Start, then Reset=1 for 1 cycle during Qdiv -> Qi next edge, outputs 0; later Start
//    with test-2 data gives test-2 results; Start pulses during Qacc/Qdiv have no effect.
//  6 Ack=0 in Qd -> Qd held 5 cycles with stable outputs; Ack=1 -> Qi next edge.

Source files
------------

// File: rtl/bg_mean_calc_if.sv
// rtl/bg_mean_calc_if.sv - start/ack handshake, lane buses and result bundle for bg_mean_calc
// master drives requests and lane data; slave returns means, count and state flags.
interface bg_mean_calc_if #(
  parameter int NUM_PE = 4
);
  localparam int CW = $clog2(NUM_PE + 1);

  logic                start;
  logic                ack;
  logic [NUM_PE-1:0]   pe_mask;
  logic [8*NUM_PE-1:0] red_sum_in;
  logic [8*NUM_PE-1:0] green_sum_in;
  logic [8*NUM_PE-1:0] blue_sum_in;
  logic [7:0]          red_exp;
  logic [7:0]          green_exp;
  logic [7:0]          blue_exp;
  logic [CW-1:0]       pe_count;
  logic                zero_cnt;
  logic                qi;
  logic                qacc;
  logic                qdiv;
  logic                qd;

  modport master (
    output start, ack, pe_mask, red_sum_in, green_sum_in, blue_sum_in,
    input  red_exp, green_exp, blue_exp, pe_count, zero_cnt, qi, qacc, qdiv, qd
  );

  modport slave (
    input  start, ack, pe_mask, red_sum_in, green_sum_in, blue_sum_in,
    output red_exp, green_exp, blue_exp, pe_count, zero_cnt, qi, qacc, qdiv, qd
  );
endinterface

// File: rtl/bg_mean_calc.sv
// rtl/bg_mean_calc.sv - rounded mean of the enabled PE lanes per colour channel
// One lane accumulated per cycle, then a shared-divisor restoring divide over ACC_W cycles.
module bg_mean_calc #(
  parameter int NUM_PE = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  bg_mean_calc_if.slave  io_bus
);
  localparam int CW    = $clog2(NUM_PE + 1);
  localparam int ACC_W = 8 + CW;
  localparam int IW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int BW    = $clog2(ACC_W + 1);

  localparam logic [3:0] S_I   = 4'b0001;
  localparam logic [3:0] S_ACC = 4'b0010;
  localparam logic [3:0] S_DIV = 4'b0100;
  localparam logic [3:0] S_D   = 4'b1000;

  logic [3:0]          r_state;
  logic [NUM_PE-1:0]   r_mask;
  logic [8*NUM_PE-1:0] r_red_lat;
  logic [8*NUM_PE-1:0] r_grn_lat;
  logic [8*NUM_PE-1:0] r_blu_lat;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_div;
  logic [BW-1:0]       r_bit;
  logic [ACC_W-1:0]    r_acc_red;
  logic [ACC_W-1:0]    r_acc_grn;
  logic [ACC_W-1:0]    r_acc_blu;
  logic [CW-1:0]       r_rem_red;
  logic [CW-1:0]       r_rem_grn;
  logic [CW-1:0]       r_rem_blu;
  logic [7:0]          r_red_exp;
  logic [7:0]          r_grn_exp;
  logic [7:0]          r_blu_exp;
  logic [CW-1:0]       r_pe_count;
  logic                r_zero_cnt;

  // One restoring step: returns {next remainder, dividend shifted left with quotient bit in LSB}.
  // The accumulator doubles as the dividend/quotient shift register during the divide.
  function automatic logic [CW+ACC_W-1:0] div_step(
    input logic [CW-1:0]    rem,
    input logic [ACC_W-1:0] dvd,
    input logic [CW-1:0]    dv
  );
    logic [CW:0] trial;
    logic        q;
    trial = {rem, dvd[ACC_W-1]};
    q     = (trial >= {1'b0, dv});
    if (q) trial = trial - {1'b0, dv};
    return {trial[CW-1:0], dvd[ACC_W-2:0], q};
  endfunction

  logic [7:0]          w_lane_red;
  logic [7:0]          w_lane_grn;
  logic [7:0]          w_lane_blu;
  logic                w_take;
  logic [ACC_W-1:0]    w_acc_red_nxt;
  logic [ACC_W-1:0]    w_acc_grn_nxt;
  logic [ACC_W-1:0]    w_acc_blu_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [ACC_W-1:0]    w_half;
  logic [CW+ACC_W-1:0] w_step_red;
  logic [CW+ACC_W-1:0] w_step_grn;
  logic [CW+ACC_W-1:0] w_step_blu;
  logic                w_last_idx;
  logic                w_last_bit;

  assign w_lane_red    = r_red_lat[8*r_idx +: 8];
  assign w_lane_grn    = r_grn_lat[8*r_idx +: 8];
  assign w_lane_blu    = r_blu_lat[8*r_idx +: 8];
  assign w_take        = r_mask[r_idx];
  assign w_acc_red_nxt = r_acc_red + (w_take ? {{CW{1'b0}}, w_lane_red} : '0);
  assign w_acc_grn_nxt = r_acc_grn + (w_take ? {{CW{1'b0}}, w_lane_grn} : '0);
  assign w_acc_blu_nxt = r_acc_blu + (w_take ? {{CW{1'b0}}, w_lane_blu} : '0);
  assign w_cnt_nxt     = r_cnt + CW'(w_take);
  assign w_half        = ACC_W'(w_cnt_nxt >> 1);
  assign w_step_red    = div_step(r_rem_red, r_acc_red, r_div);
  assign w_step_grn    = div_step(r_rem_grn, r_acc_grn, r_div);
  assign w_step_blu    = div_step(r_rem_blu, r_acc_blu, r_div);
  assign w_last_idx    = (r_idx == IW'(NUM_PE - 1));
  assign w_last_bit    = (r_bit == BW'(ACC_W - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_I;
      r_mask     <= '0;
      r_red_lat  <= '0;
      r_grn_lat  <= '0;
      r_blu_lat  <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_acc_red  <= '0;
      r_acc_grn  <= '0;
      r_acc_blu  <= '0;
      r_rem_red  <= '0;
      r_rem_grn  <= '0;
      r_rem_blu  <= '0;
      r_red_exp  <= '0;
      r_grn_exp  <= '0;
      r_blu_exp  <= '0;
      r_pe_count <= '0;
      r_zero_cnt <= 1'b0;
    end else begin
      case (r_state)
        S_I: begin
          if (io_bus.start) begin
            r_mask    <= io_bus.pe_mask;
            r_red_lat <= io_bus.red_sum_in;
            r_grn_lat <= io_bus.green_sum_in;
            r_blu_lat <= io_bus.blue_sum_in;
            r_acc_red <= '0;
            r_acc_grn <= '0;
            r_acc_blu <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_state   <= S_ACC;
          end
        end
        S_ACC: begin
          r_cnt <= w_cnt_nxt;
          r_idx <= r_idx + 1'b1;
          if (w_last_idx) begin
            // Fold the round-half-up bias into the dividend on the way into the divide.
            r_acc_red <= w_acc_red_nxt + w_half;
            r_acc_grn <= w_acc_grn_nxt + w_half;
            r_acc_blu <= w_acc_blu_nxt + w_half;
            r_div     <= w_cnt_nxt;
            r_rem_red <= '0;
            r_rem_grn <= '0;
            r_rem_blu <= '0;
            r_bit     <= '0;
            r_state   <= S_DIV;
          end else begin
            r_acc_red <= w_acc_red_nxt;
            r_acc_grn <= w_acc_grn_nxt;
            r_acc_blu <= w_acc_blu_nxt;
          end
        end
        S_DIV: begin
          {r_rem_red, r_acc_red} <= w_step_red;
          {r_rem_grn, r_acc_grn} <= w_step_grn;
          {r_rem_blu, r_acc_blu} <= w_step_blu;
          r_bit <= r_bit + 1'b1;
          if (w_last_bit) begin
            r_red_exp  <= (r_div == '0) ? 8'd0 : w_step_red[7:0];
            r_grn_exp  <= (r_div == '0) ? 8'd0 : w_step_grn[7:0];
            r_blu_exp  <= (r_div == '0) ? 8'd0 : w_step_blu[7:0];
            r_pe_count <= r_div;
            r_zero_cnt <= (r_div == '0);
            r_state    <= S_D;
          end
        end
        S_D: begin
          if (io_bus.ack) r_state <= S_I;
        end
        default: r_state <= S_I;
      endcase
    end
  end

  assign io_bus.red_exp   = r_red_exp;
  assign io_bus.green_exp = r_grn_exp;
  assign io_bus.blue_exp  = r_blu_exp;
  assign io_bus.pe_count  = r_pe_count;
  assign io_bus.zero_cnt  = r_zero_cnt;
  assign io_bus.qi        = r_state[0];
  assign io_bus.qacc      = r_state[1];
  assign io_bus.qdiv      = r_state[2];
  assign io_bus.qd        = r_state[3];
endmodule

// File: tb/tb_bg_mean_calc.sv
// tb/tb_bg_mean_calc.sv - randomized bench for bg_mean_calc against a cycle-count/arithmetic model
module tb_bg_mean_calc;
  localparam int NUM_PE = 4;
  localparam int ACC_W  = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bg_mean_calc_if #(.NUM_PE(NUM_PE)) bus ();
  bg_mean_calc #(.NUM_PE(NUM_PE)) dut (.i_clk(clk), .i_reset(rst), .io_bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lane_mean(input logic [NUM_PE-1:0] m, input logic [8*NUM_PE-1:0] b);
    int s = 0;
    int c = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (m[i]) begin
        s += int'(b[8*i +: 8]);
        c++;
      end
    end
    return (c == 0) ? 0 : (s + c / 2) / c;
  endfunction

  // Model: phase 0=idle 1=accumulate 2=divide 3=done; timing derived from cycle counts alone.
  int m_phase = 0;
  int m_t = 0;
  int m_red = 0, m_grn = 0, m_blu = 0, m_cnt = 0, m_zero = 0;
  int p_red = 0, p_grn = 0, p_blu = 0, p_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_t = 0;
      m_red = 0; m_grn = 0; m_blu = 0; m_cnt = 0; m_zero = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          p_red = lane_mean(bus.pe_mask, bus.red_sum_in);
          p_grn = lane_mean(bus.pe_mask, bus.green_sum_in);
          p_blu = lane_mean(bus.pe_mask, bus.blue_sum_in);
          p_cnt = $countones(bus.pe_mask);
          m_t = 0;
          m_phase = 1;
        end
        1, 2: begin
          m_t++;
          if (m_t == NUM_PE) m_phase = 2;
          if (m_t == NUM_PE + ACC_W) begin
            m_phase = 3;
            m_red = p_red; m_grn = p_grn; m_blu = p_blu;
            m_cnt = p_cnt; m_zero = (p_cnt == 0) ? 1 : 0;
          end
        end
        default: if (bus.ack) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state_flags", {bus.qd, bus.qdiv, bus.qacc, bus.qi}, 1 << m_phase);
      check("outputs", {bus.red_exp, bus.green_exp, bus.blue_exp, bus.pe_count, bus.zero_cnt},
            (m_red << 20) | (m_grn << 12) | (m_blu << 4) | (m_cnt << 1) | m_zero);
    end
  end

  task automatic run_txn(input logic [3:0] m, input logic [31:0] r, input logic [31:0] g,
                         input logic [31:0] b, input int ack_dly, input bit noise, output int lat);
    bus.pe_mask = m; bus.red_sum_in = r; bus.green_sum_in = g; bus.blue_sum_in = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    if (noise) begin
      bus.pe_mask = 4'($urandom); bus.red_sum_in = $urandom;
      bus.green_sum_in = $urandom; bus.blue_sum_in = $urandom;
    end
    while (!bus.qd && lat < 100) begin
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    if (!bus.qd) check("qd_timeout", 0, 1);
    repeat (ack_dly) begin @(posedge clk); #1; end
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
  endtask

  localparam logic [31:0] RED2 = {8'd61, 8'd61, 8'd61, 8'd61};
  localparam logic [31:0] GRN2 = {8'd41, 8'd30, 8'd20, 8'd10};
  localparam logic [31:0] BLU2 = 32'hFFFF_FFFF;
  localparam logic [31:0] RED3 = {8'd200, 8'd200, 8'd11, 8'd10};

  initial begin
    int lat;
    int n;
    bus.start = 1'b0; bus.ack = 1'b0; bus.pe_mask = '0;
    bus.red_sum_in = '0; bus.green_sum_in = '0; bus.blue_sum_in = '0;
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_qi", bus.qi, 1);
    check("rst_busy", {bus.qacc, bus.qdiv, bus.qd}, 0);
    check("rst_exp", {bus.red_exp, bus.green_exp, bus.blue_exp}, 0);
    check("rst_cnt", {bus.pe_count, bus.zero_cnt}, 0);
    rst = 1'b0;

    check("pin_model_green", lane_mean(4'b1111, GRN2), 25);
    check("pin_model_red3", lane_mean(4'b0011, RED3), 11);

    run_txn(4'b1111, RED2, GRN2, BLU2, 0, 1'b0, lat);
    check("t2_lat", lat, 16);
    check("t2_red", bus.red_exp, 61);
    check("t2_green", bus.green_exp, 25);
    check("t2_blue", bus.blue_exp, 255);
    check("t2_cnt", bus.pe_count, 4);
    check("t2_zero", bus.zero_cnt, 0);

    run_txn(4'b0011, RED3, $urandom, $urandom, 1, 1'b0, lat);
    check("t3_red", bus.red_exp, 11);
    check("t3_cnt", bus.pe_count, 2);

    // Abort in the middle of the divide.
    bus.pe_mask = 4'b1111; bus.red_sum_in = RED2; bus.green_sum_in = GRN2; bus.blue_sum_in = BLU2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.qdiv && n < 50) begin @(posedge clk); #1; n++; end
    check("t5_reach_div", bus.qdiv, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_qi", bus.qi, 1);
    check("t5_rst_exp", {bus.red_exp, bus.green_exp, bus.blue_exp, bus.pe_count}, 0);
    run_txn(4'b1111, RED2, GRN2, BLU2, 0, 1'b1, lat);
    check("t5_lat", lat, 16);
    check("t5_red", bus.red_exp, 61);
    check("t5_green", bus.green_exp, 25);
    check("t5_blue", bus.blue_exp, 255);

    run_txn(4'b0000, $urandom, $urandom, $urandom, 0, 1'b0, lat);
    check("t4_lat", lat, 16);
    check("t4_exp", {bus.red_exp, bus.green_exp, bus.blue_exp}, 0);
    check("t4_zero", bus.zero_cnt, 1);
    check("t4_cnt", bus.pe_count, 0);

    run_txn(4'b1010, $urandom, $urandom, $urandom, 5, 1'b0, lat);
    check("t6_qi_after_ack", bus.qi, 1);

    for (int i = 0; i < 40; i++) begin
      run_txn(4'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'b1, lat);
      check("rand_lat", lat, 16);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
